// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encoding and width helper
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Number of bits needed to hold values 0..value-1
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with a tick on the last cycle of each period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap at the end of each period; clear restarts phase at a new frame
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (width, parity, stop bits, bit period)
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);

  if ((CLKS_PER_BIT < 2) || (PARITY < PAR_NONE) || (PARITY > PAR_ODD) ||
      !((STOP_BITS == 1) || (STOP_BITS == 2)) ||
      (DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_params
    $error("uart_tx_cfg: illegal parameter combination");
  end

  // Bit counter indexes data bits and, reused, stop bits
  localparam int BIT_W = clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 par_q;
  logic                 accept;
  logic                 tick;

  assign accept = start && !busy_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .tick (tick)
  );

  // Frame sequencer; txd and busy are registered so the line never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          txd_q <= 1'b1;
          if (accept) begin
            state_q   <= ST_START;
            shift_q   <= data;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            txd_q     <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state_q   <= ST_DATA;
            txd_q     <= shift_q[0];
            par_q     <= ^shift_q;
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              if (PARITY != PAR_NONE) begin
                state_q <= ST_PARITY;
                txd_q   <= (PARITY == PAR_ODD) ? ~par_q : par_q;
              end else begin
                state_q <= ST_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q   <= ST_STOP;
            txd_q     <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              txd_q   <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;
  // Decoded from registers only: final stop bit, last cycle of its period
  assign done = (state_q == ST_STOP) && (bit_cnt_q == LAST_STOP) && tick;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - table and scoreboard bench for uart_tx_cfg in four configurations
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic [7:0] data_a [4];
  logic [3:0] txd_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .data(data_a[0][7:0]),
    .txd(txd_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .data(data_a[1][7:0]),
    .txd(txd_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .data(data_a[2][7:0]),
    .txd(txd_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .data(data_a[3][6:0]),
    .txd(txd_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  // slots: transmitted bit per 4-cycle slot, slot 0 in bit 15
  typedef struct packed {
    logic [1:0]  idx;
    logic [7:0]  data;
    logic [15:0] slots;
    logic [3:0]  nslots;
  } vec_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] slots;
    logic [3:0]  nslots;
  } exp_t;

  localparam logic [15:0] S_58_N = 16'b0000110101000000;
  localparam logic [15:0] S_A5_N = 16'b0101001011000000;
  localparam logic [15:0] S_00_N = 16'b0000000001000000;

  int   checks = 0;
  int   fails  = 0;
  exp_t sb_q [$];
  int   exp_done [4] = '{default: 0};
  int   done_cnt [4] = '{default: 0};
  logic in_frame [4];
  int   cyc [4];
  int   bcnt [4];
  logic [63:0] cap [4];
  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [15:0] s, input int n);
    exp_t e;
    e.idx    = 2'(k);
    e.slots  = s;
    e.nslots = 4'(n);
    sb_q.push_back(e);
    exp_done[k]++;
  endtask

  task automatic send(input int k, input logic [7:0] d);
    data_a[k]  = d;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int max_cycles);
    int n;
    n = 0;
    while (!done_v[k] && (n < max_cycles)) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_v[k]), 64'd1);
    @(negedge clk);
    chk("idle_after_done", 64'(busy_v[k]), 64'd0);
  endtask

  task automatic score(input int k);
    exp_t        e;
    int          n;
    logic [63:0] expv;
    logic [63:0] mask;
    if (sb_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_frame: dut %0d produced a frame, 0 expected", k);
    end else begin
      e    = sb_q.pop_front();
      n    = int'(e.nslots) * 4;
      expv = '0;
      mask = '0;
      for (int c = 0; c < n; c++) begin
        expv[c] = e.slots[15 - c / 4];
        mask[c] = 1'b1;
      end
      chk("frame_dut", 64'(k), 64'(e.idx));
      chk("frame_len", 64'(cyc[k]), 64'(n));
      chk("busy_len", 64'(bcnt[k]), 64'(n));
      chk("frame_bits", cap[k] & mask, expv);
    end
  endtask

  // Line monitor: captures txd per cycle of each frame and scores it on done
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (!rst_n) begin
          in_frame[k] = 1'b0;
          cyc[k]      = 0;
          bcnt[k]     = 0;
          cap[k]      = '0;
        end else begin
          if (!in_frame[k] && busy_v[k]) begin
            in_frame[k] = 1'b1;
            cyc[k]      = 0;
            bcnt[k]     = 0;
            cap[k]      = '0;
          end
          if (in_frame[k]) begin
            if (cyc[k] < 64) cap[k][cyc[k]] = txd_v[k];
            cyc[k]++;
            if (busy_v[k]) bcnt[k]++;
          end else begin
            chk("idle_txd", 64'(txd_v[k]), 64'd1);
          end
          if (done_v[k]) begin
            done_cnt[k]++;
            score(k);
            in_frame[k] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int gap;
    int ngaps;
    int low_txd;
    int bad_done;
    int busy_seen;
    int d0;

    vecs[0] = '{idx: 2'd0, data: 8'h58, slots: S_58_N,                nslots: 4'd10};
    vecs[1] = '{idx: 2'd1, data: 8'h58, slots: 16'b0000110101100000,  nslots: 4'd11};
    vecs[2] = '{idx: 2'd2, data: 8'h58, slots: 16'b0000110100100000,  nslots: 4'd11};
    vecs[3] = '{idx: 2'd3, data: 8'h55, slots: 16'b0101010101100000,  nslots: 4'd11};
    vecs[4] = '{idx: 2'd0, data: 8'hA5, slots: S_A5_N,                nslots: 4'd10};
    vecs[5] = '{idx: 2'd0, data: 8'h00, slots: S_00_N,                nslots: 4'd10};
    vecs[6] = '{idx: 2'd1, data: 8'hFF, slots: 16'b0111111110100000,  nslots: 4'd11};
    vecs[7] = '{idx: 2'd2, data: 8'h01, slots: 16'b0100000000100000,  nslots: 4'd11};
    vecs[8] = '{idx: 2'd3, data: 8'h7F, slots: 16'b0111111111100000,  nslots: 4'd11};

    rst_n   = 1'b0;
    start_v = '0;
    for (int k = 0; k < 4; k++) data_a[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_txd", 64'(txd_v[k]), 64'd1);
      chk("reset_busy", 64'(busy_v[k]), 64'd0);
      chk("reset_done", 64'(done_v[k]), 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames across the four configurations
    for (int i = 0; i < 9; i++) begin
      push(int'(vecs[i].idx), vecs[i].slots, int'(vecs[i].nslots));
      send(int'(vecs[i].idx), vecs[i].data);
      wait_done(int'(vecs[i].idx), 100);
      repeat (2) @(negedge clk);
    end

    // Requests while busy are dropped
    d0 = done_cnt[0];
    push(0, S_58_N, 10);
    send(0, 8'h58);
    repeat (9) @(posedge clk);
    #1;
    data_a[0]  = 8'hFF;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_done(0, 100);
    busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy_v[0]) busy_seen++;
    end
    chk("ignored_busy_cycles", 64'(busy_seen), 64'd0);
    chk("ignored_done_count", 64'(done_cnt[0] - d0), 64'd1);

    // start held for 200 edges; data changes mid first frame
    push(0, S_58_N, 10);
    for (int j = 0; j < 4; j++) push(0, S_A5_N, 10);
    @(posedge clk);
    #1;
    data_a[0]  = 8'h58;
    start_v[0] = 1'b1;
    seen  = 0;
    gap   = 0;
    ngaps = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy_v[0]) begin
        if ((seen != 0) && (gap > 0)) begin
          chk("b2b_gap", 64'(gap), 64'd1);
          ngaps++;
        end
        seen = 1;
        gap  = 0;
      end else if (seen != 0) begin
        gap++;
      end
      if (i == 20) data_a[0] = 8'hA5;
      @(posedge clk);
    end
    #1;
    start_v[0] = 1'b0;
    chk("b2b_gap_count", 64'(ngaps), 64'd4);
    wait_done(0, 100);
    repeat (5) @(negedge clk);

    // Asynchronous reset at cycle 17 of a frame
    send(0, 8'h58);
    repeat (16) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_txd", 64'(txd_v[0]), 64'd1);
    chk("async_rst_busy", 64'(busy_v[0]), 64'd0);
    chk("async_rst_done", 64'(done_v[0]), 64'd0);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    low_txd  = 0;
    bad_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (!txd_v[0]) low_txd++;
      if (done_v[0]) bad_done++;
    end
    chk("post_rst_txd_low", 64'(low_txd), 64'd0);
    chk("post_rst_done", 64'(bad_done), 64'd0);
    push(0, S_00_N, 10);
    send(0, 8'h00);
    wait_done(0, 100);
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk("done_count", 64'(done_cnt[k]), 64'(exp_done[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
